sudoku_group_sweeper: RTL and testbench
=======================================

# sudoku_group_sweeper

Sequencer that drives one sudoku group (row, column or box) of nine `sudoku_cell` instances over their shared 9-bit value bus. On each `start` it:
- reads every cell's value;
- broadcasts the group's elimination mask with `latch_valid`;
- reads back every cell's candidate set;
- writes any "hidden single" (a digit possible in exactly one unsolved cell) into that cell.

It sits directly upstream of the cell array; the top-level solver schedules the 27 groups.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-low (0 = reset)
- `start`  in  1  begin a sweep; sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse at end of sweep
- `conflict`  out  1  sweep found an inconsistency; held until next accepted `start`
- `placed_count`  out  4  hidden singles written this sweep, 0–9; held
- `solved_count`  out  4  cells with nonzero value at READ_VAL, 0–9; held
- `cell_oe`  out  9  one-hot output enable to cell i (bit 0 = cell 0)
- `cell_we`  out  9  one-hot write enable to cell i
- `address`  out  2  cell register select (0 value, 2 valid)
- `latch_valid`  out  1  broadcast to all nine cells
- `bus_in`  in  9  value bus as seen by the block (bits 9:1 map to [8:0])
- `bus_out`  out  9  value the block drives onto the bus
- `bus_drive`  out  1  top level drives `bus_out` onto the bus when high

## Operation
- Reset values: every output is 0, and the state is IDLE. Reset during any state aborts the sweep immediately and issues no `done`.
- Bus rule: `bus_drive` and any `cell_oe` bit are never high in the same cycle. `cell_we` is never set without `bus_drive`.
- IDLE → READ_VAL on `start`. Entering READ_VAL clears `conflict`, counts, `mask`, `solved[8:0]`, `once`, `multi` and `hidden`.
- READ_VAL, index i = 0..8, one cycle each:
  - `address` = 0 and `cell_oe[i]` = 1; `bus_in` is sampled at the end of the cycle.
  - If `bus_in` ≠ 0: set `solved[i]` and increment `solved_count`.
  - If `bus_in & mask` ≠ 0, or `bus_in` is nonzero and not one-hot: set `conflict`.
  - Then `mask |= bus_in`.
- ELIM, one cycle: `bus_drive` = 1, `bus_out` = ~`mask`, `latch_valid` = 1, `address` = 0, `cell_oe` = `cell_we` = 0.
- READ_VALID, i = 0..8, one cycle each:
  - `address` = 2 and `cell_oe[i]` = 1.
  - If `solved[i]` = 0 and `bus_in` = 0: set `conflict`.
  - Update `multi |= once & bus_in`, then `once |= bus_in` (both from the values before this cycle).
- After READ_VALID: `hidden` = `once` & ~`multi` & ~`mask`.
  - If `conflict` is set or `hidden` = 0, go to DONE.
  - Otherwise go to PLACE_RD with i = 0.
- PLACE_RD(i): `address` = 2, `cell_oe[i]` = 1; let hit = `bus_in` & `hidden`.
  - If `solved[i]` = 1 or hit = 0: advance to i+1.
  - If hit has two or more bits set: set `conflict` and advance; no write.
  - Otherwise latch hit into `wdata` and go to PLACE_WR(i).
- PLACE_WR(i), one cycle: `bus_drive` = 1, `bus_out` = `wdata`, `address` = 0, `cell_we[i]` = 1. Increment `placed_count` and advance to i+1.
- PLACE scan ends after i = 8 → DONE.
- DONE, one cycle: `done` = 1, `busy` = 0, then IDLE. Result outputs hold until the next accepted `start`.
- `start` asserted while `busy` is ignored, and is not queued.
- Counts are 4-bit and saturate naturally; the maximum is 9, so they never wrap.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- READ_VAL occupies cycles 1–9, ELIM cycle 10, READ_VALID cycles 11–19.
- No PLACE: `done` is high in cycle 20.
- With PLACE: PLACE spans cycles 20 to 28+W, where W = `placed_count`. `done` is high in cycle 29+W.
- `busy` is high in cycles 1 through the cycle before `done`.
- The cell's `valid` update from `latch_valid` at the end of cycle 10 is visible to the READ_VALID reads in cycles 11+.
- All control outputs are registered-state decodes; there are no combinational paths from `bus_in` to outputs.

## Test plan
- Empty group, all cells value 0 and valid 0x1FF → after `start`:
  - `latch_valid` pulses with `bus_out` = 0x1FF in cycle 10;
  - `hidden` = 0;
  - `done` in cycle 20 with `conflict` 0, `solved_count` 0, `placed_count` 0.
- Cells 0–7 solved with digits 1–8, cell 8 unsolved:
  - ELIM drives 0x100;
  - cell 8 reads valid 0x100, giving hidden 0x100;
  - PLACE_WR(8) writes 0x100;
  - `placed_count` 1, `solved_count` 8, `done` in cycle 30.
- Two cells both hold value 0x004 → `conflict` = 1 after READ_VAL, PLACE is skipped, `done` in cycle 20.
- Digit 5 (0x010) appears in the valid set of cell 3 only, and cell 3's valid is 0x011 with 0x001 in other cells → cell 3 is written 0x010, `placed_count` 1.
- Unsolved cell reads valid 0 in READ_VALID → `conflict` set, `done` in cycle 20.
- Reset pulled low in cycle 12 → all outputs 0 next cycle, no `done`. A new `start` then runs a full sweep normally. A `start` raised in cycle 5 is ignored.

Source files
------------

// File: rtl/sudoku_group_sweeper_if.sv
// Bus and handshake bundle between the group sweeper and its nine-cell group.
interface sudoku_group_sweeper_if;
   localparam int unsigned N_CELLS = 9;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned ADDR_W  = 2;

   logic                start;
   logic                busy;
   logic                done;
   logic                conflict;
   logic [CNT_W-1:0]    placed_count;
   logic [CNT_W-1:0]    solved_count;
   logic [N_CELLS-1:0]  cell_oe;
   logic [N_CELLS-1:0]  cell_we;
   logic [ADDR_W-1:0]   address;
   logic                latch_valid;
   logic [N_CELLS-1:0]  bus_in;
   logic [N_CELLS-1:0]  bus_out;
   logic                bus_drive;

   modport master (
      input  start, bus_in,
      output busy, done, conflict, placed_count, solved_count,
             cell_oe, cell_we, address, latch_valid, bus_out, bus_drive
   );

   modport slave (
      output start, bus_in,
      input  busy, done, conflict, placed_count, solved_count,
             cell_oe, cell_we, address, latch_valid, bus_out, bus_drive
   );
endinterface

// File: rtl/sudoku_group_sweeper.sv
// Sweeps one sudoku group: reads values, broadcasts elimination mask,
// reads candidates back and writes any hidden singles.
module sudoku_group_sweeper (
   input  logic                   clk,
   input  logic                   reset,
   sudoku_group_sweeper_if.master sw
);
   localparam int unsigned N_CELLS = 9;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned ADDR_W  = 2;

   typedef enum logic [2:0] {
      S_IDLE, S_READ_VAL, S_ELIM, S_READ_VALID, S_PLACE_RD, S_PLACE_WR, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [N_CELLS-1:0]  mask_q, mask_d, solved_q, solved_d;
   logic [N_CELLS-1:0]  once_q, once_d, multi_q, multi_d;
   logic [N_CELLS-1:0]  hidden_q, hidden_d, wdata_q, wdata_d;
   logic                conflict_q, conflict_d;
   logic [CNT_W-1:0]    placed_q, placed_d, solvedc_q, solvedc_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic                latch_valid_q, latch_valid_d, bus_drive_q, bus_drive_d;
   logic [N_CELLS-1:0]  cell_oe_q, cell_oe_d, cell_we_q, cell_we_d;
   logic [N_CELLS-1:0]  bus_out_q, bus_out_d;
   logic [ADDR_W-1:0]   address_q, address_d;

   logic                last_c;
   logic [N_CELLS-1:0]  hit_c, once_c, multi_c, hidden_c, onehot_c;

   // Next-state, datapath and registered output decode.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      mask_d        = mask_q;
      solved_d      = solved_q;
      once_d        = once_q;
      multi_d       = multi_q;
      hidden_d      = hidden_q;
      wdata_d       = wdata_q;
      conflict_d    = conflict_q;
      placed_d      = placed_q;
      solvedc_d     = solvedc_q;
      last_c        = (idx_q == IDX_W'(N_CELLS - 1));
      hit_c         = sw.bus_in & hidden_q;
      once_c        = once_q | sw.bus_in;
      multi_c       = multi_q | (once_q & sw.bus_in);
      hidden_c      = once_c & ~multi_c & ~mask_q;

      case (state_q)
         S_IDLE: begin
            if (sw.start) begin
               state_d    = S_READ_VAL;
               idx_d      = '0;
               conflict_d = 1'b0;
               placed_d   = '0;
               solvedc_d  = '0;
               mask_d     = '0;
               solved_d   = '0;
               once_d     = '0;
               multi_d    = '0;
               hidden_d   = '0;
            end
         end
         S_READ_VAL: begin
            if (sw.bus_in != '0) begin
               solved_d[idx_q] = 1'b1;
               solvedc_d       = solvedc_q + CNT_W'(1);
            end
            // Duplicate digit, or a value that is not a single digit.
            if (((sw.bus_in & mask_q) != '0) ||
                ((sw.bus_in & (sw.bus_in - N_CELLS'(1))) != '0))
               conflict_d = 1'b1;
            mask_d = mask_q | sw.bus_in;
            if (last_c) begin
               state_d = S_ELIM;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_ELIM: begin
            state_d = S_READ_VALID;
            idx_d   = '0;
         end
         S_READ_VALID: begin
            if (!solved_q[idx_q] && (sw.bus_in == '0))
               conflict_d = 1'b1;
            once_d  = once_c;
            multi_d = multi_c;
            if (last_c) begin
               hidden_d = hidden_c;
               idx_d    = '0;
               state_d  = (conflict_d || (hidden_c == '0)) ? S_DONE : S_PLACE_RD;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_PLACE_RD: begin
            if (!solved_q[idx_q] && (hit_c != '0) &&
                ((hit_c & (hit_c - N_CELLS'(1))) == '0)) begin
               wdata_d = hit_c;
               state_d = S_PLACE_WR;
            end else begin
               if (!solved_q[idx_q] && (hit_c != '0))
                  conflict_d = 1'b1;
               if (last_c) state_d = S_DONE;
               else        idx_d   = idx_q + IDX_W'(1);
            end
         end
         S_PLACE_WR: begin
            placed_d = placed_q + CNT_W'(1);
            if (last_c) begin
               state_d = S_DONE;
            end else begin
               state_d = S_PLACE_RD;
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they line up with it.
      onehot_c      = N_CELLS'(1) << idx_d;
      busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d        = (state_d == S_DONE);
      cell_oe_d     = ((state_d == S_READ_VAL) || (state_d == S_READ_VALID) ||
                       (state_d == S_PLACE_RD)) ? onehot_c : '0;
      cell_we_d     = (state_d == S_PLACE_WR) ? onehot_c : '0;
      address_d     = ((state_d == S_READ_VALID) || (state_d == S_PLACE_RD)) ?
                      ADDR_W'(2) : ADDR_W'(0);
      latch_valid_d = (state_d == S_ELIM);
      bus_drive_d   = (state_d == S_ELIM) || (state_d == S_PLACE_WR);
      bus_out_d     = (state_d == S_ELIM)     ? ~mask_d :
                      (state_d == S_PLACE_WR) ? wdata_d : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         mask_q        <= '0;
         solved_q      <= '0;
         once_q        <= '0;
         multi_q       <= '0;
         hidden_q      <= '0;
         wdata_q       <= '0;
         conflict_q    <= 1'b0;
         placed_q      <= '0;
         solvedc_q     <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         cell_oe_q     <= '0;
         cell_we_q     <= '0;
         address_q     <= '0;
         latch_valid_q <= 1'b0;
         bus_drive_q   <= 1'b0;
         bus_out_q     <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         mask_q        <= mask_d;
         solved_q      <= solved_d;
         once_q        <= once_d;
         multi_q       <= multi_d;
         hidden_q      <= hidden_d;
         wdata_q       <= wdata_d;
         conflict_q    <= conflict_d;
         placed_q      <= placed_d;
         solvedc_q     <= solvedc_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         cell_oe_q     <= cell_oe_d;
         cell_we_q     <= cell_we_d;
         address_q     <= address_d;
         latch_valid_q <= latch_valid_d;
         bus_drive_q   <= bus_drive_d;
         bus_out_q     <= bus_out_d;
      end
   end

   assign sw.busy         = busy_q;
   assign sw.done         = done_q;
   assign sw.conflict     = conflict_q;
   assign sw.placed_count = placed_q;
   assign sw.solved_count = solvedc_q;
   assign sw.cell_oe      = cell_oe_q;
   assign sw.cell_we      = cell_we_q;
   assign sw.address      = address_q;
   assign sw.latch_valid  = latch_valid_q;
   assign sw.bus_out      = bus_out_q;
   assign sw.bus_drive    = bus_drive_q;
endmodule

// File: tb/tb_sudoku_group_sweeper.sv
// Bench for sudoku_group_sweeper: nine behavioural cells on the bus, a
// rule-level expected trace per sweep, and a per-cycle compare process.
module tb_sudoku_group_sweeper;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sudoku_group_sweeper_if sw();
   sudoku_group_sweeper dut (.clk(clk), .reset(reset), .sw(sw));

   typedef struct {
      int         cyc;
      logic       busy, done, lv, drive, res, conf;
      logic [8:0] oe, we, bout;
      logic [1:0] addr;
      logic [3:0] placed, solved;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       pend_q[$];
   int         total = 0;
   int         bad   = 0;
   int         dut_done_cyc;
   logic [8:0] iv[9], ivl[9];
   logic [8:0] cval[9], cvld[9];
   logic       ld = 1'b0;
   logic [8:0] bus_c;
   logic [8:0] model_elim;
   logic [8:0] model_hidden;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Nine cells: load, ELIM latch on unsolved cells, and writes.
   always @(posedge clk) begin
      for (int i = 0; i < 9; i++) begin
         if (ld) begin
            cval[i] <= iv[i];
            cvld[i] <= ivl[i];
         end else if (sw.cell_we[i]) begin
            cval[i] <= sw.bus_out;
            cvld[i] <= sw.bus_out;
         end else if (sw.latch_valid && cval[i] == 9'h0) begin
            cvld[i] <= cvld[i] & sw.bus_out;
         end
      end
   end

   always_comb begin
      bus_c = 9'h0;
      for (int i = 0; i < 9; i++)
         if (sw.cell_oe[i]) bus_c = bus_c | ((sw.address == 2'd0) ? cval[i] : cvld[i]);
   end
   assign sw.bus_in = bus_c;

   function automatic exp_t mk(input int cyc);
      exp_t e;
      e.cyc = cyc; e.busy = 1'b1; e.done = 1'b0; e.lv = 1'b0; e.drive = 1'b0;
      e.res = 1'b0; e.conf = 1'b0; e.oe = 9'h0; e.we = 9'h0; e.bout = 9'h0;
      e.addr = 2'd0; e.placed = 4'd0; e.solved = 4'd0;
      return e;
   endfunction

   // Expected per-cycle behaviour derived from the group's initial contents.
   task automatic build_expected();
      logic [8:0] mask, hidden, hit, pv[9];
      logic       solved[9];
      logic       conf;
      int         scnt, placed, cnt, cyc;
      exp_t       e;
      pend_q.delete();
      mask = 9'h0; conf = 1'b0; scnt = 0; placed = 0;
      for (int i = 0; i < 9; i++) begin
         solved[i] = (iv[i] != 9'h0);
         if (solved[i]) begin
            scnt++;
            if ((iv[i] & mask) != 9'h0 || $countones(iv[i]) > 1) conf = 1'b1;
         end
         mask = mask | iv[i];
      end
      for (int i = 0; i < 9; i++) begin
         pv[i] = solved[i] ? ivl[i] : (ivl[i] & ~mask);
         if (!solved[i] && pv[i] == 9'h0) conf = 1'b1;
      end
      hidden = 9'h0;
      for (int d = 0; d < 9; d++) begin
         cnt = 0;
         for (int i = 0; i < 9; i++) cnt += int'(pv[i][d]);
         if (cnt == 1 && !mask[d]) hidden[d] = 1'b1;
      end
      model_elim = ~mask; model_hidden = hidden;
      cyc = 1;
      for (int i = 0; i < 9; i++) begin
         e = mk(cyc++); e.oe = 9'h1 << i; pend_q.push_back(e);
      end
      e = mk(cyc++); e.drive = 1'b1; e.lv = 1'b1; e.bout = ~mask; pend_q.push_back(e);
      for (int i = 0; i < 9; i++) begin
         e = mk(cyc++); e.oe = 9'h1 << i; e.addr = 2'd2; pend_q.push_back(e);
      end
      if (!conf && hidden != 9'h0) begin
         for (int i = 0; i < 9; i++) begin
            e = mk(cyc++); e.oe = 9'h1 << i; e.addr = 2'd2; pend_q.push_back(e);
            hit = pv[i] & hidden;
            if (!solved[i] && hit != 9'h0) begin
               if ($countones(hit) > 1) conf = 1'b1;
               else begin
                  e = mk(cyc++); e.we = 9'h1 << i; e.drive = 1'b1; e.bout = hit;
                  pend_q.push_back(e);
                  placed++;
               end
            end
         end
      end
      e = mk(cyc++); e.busy = 1'b0; e.done = 1'b1; e.res = 1'b1; e.conf = conf;
      e.placed = 4'(placed); e.solved = 4'(scnt); pend_q.push_back(e);
      e.cyc = cyc; e.done = 1'b0; pend_q.push_back(e);
   endtask

   // Per-cycle compare against the expected trace.
   initial begin : compare
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk($sformatf("c%0d_busy", e.cyc), int'(sw.busy), int'(e.busy));
            chk($sformatf("c%0d_done", e.cyc), int'(sw.done), int'(e.done));
            chk($sformatf("c%0d_oe", e.cyc), int'(sw.cell_oe), int'(e.oe));
            chk($sformatf("c%0d_we", e.cyc), int'(sw.cell_we), int'(e.we));
            chk($sformatf("c%0d_addr", e.cyc), int'(sw.address), int'(e.addr));
            chk($sformatf("c%0d_latch", e.cyc), int'(sw.latch_valid), int'(e.lv));
            chk($sformatf("c%0d_drive", e.cyc), int'(sw.bus_drive), int'(e.drive));
            if (e.drive) chk($sformatf("c%0d_bus_out", e.cyc), int'(sw.bus_out), int'(e.bout));
            if (e.res) begin
               chk($sformatf("c%0d_conflict", e.cyc), int'(sw.conflict), int'(e.conf));
               chk($sformatf("c%0d_placed", e.cyc), int'(sw.placed_count), int'(e.placed));
               chk($sformatf("c%0d_solved", e.cyc), int'(sw.solved_count), int'(e.solved));
            end
            if (sw.done) dut_done_cyc = e.cyc;
         end
      end
   end

   task automatic load_cells();
      @(negedge clk); ld = 1'b1;
      @(negedge clk); ld = 1'b0;
   endtask

   task automatic run_sweep();
      load_cells();
      build_expected();
      dut_done_cyc = -1;
      @(negedge clk); sw.start = 1'b1;
      @(posedge clk); #1; sw.start = 1'b0;
      foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
      wait (exp_q.size() == 0);
   endtask

   task automatic chk_result(input string t, input int cyc, input int conf,
                             input int placed, input int solved);
      chk({t, "_done_cycle"}, dut_done_cyc, cyc);
      chk({t, "_conflict"}, int'(sw.conflict), conf);
      chk({t, "_placed"}, int'(sw.placed_count), placed);
      chk({t, "_solved"}, int'(sw.solved_count), solved);
   endtask

   task automatic chk_zero(input string t);
      chk({t, "_busy"}, int'(sw.busy), 0);
      chk({t, "_done"}, int'(sw.done), 0);
      chk({t, "_conflict"}, int'(sw.conflict), 0);
      chk({t, "_placed"}, int'(sw.placed_count), 0);
      chk({t, "_solved"}, int'(sw.solved_count), 0);
      chk({t, "_oe"}, int'(sw.cell_oe), 0);
      chk({t, "_we"}, int'(sw.cell_we), 0);
      chk({t, "_addr"}, int'(sw.address), 0);
      chk({t, "_latch"}, int'(sw.latch_valid), 0);
      chk({t, "_bus_out"}, int'(sw.bus_out), 0);
      chk({t, "_drive"}, int'(sw.bus_drive), 0);
   endtask

   task automatic set_empty();
      for (int i = 0; i < 9; i++) begin iv[i] = 9'h0; ivl[i] = 9'h1FF; end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic saw_done;
      int   r;
      reset = 1'b0; sw.start = 1'b0;
      set_empty();
      repeat (3) @(negedge clk);
      chk_zero("reset");
      reset = 1'b1;

      // Empty group.
      set_empty(); run_sweep();
      chk("t1_model_elim", int'(model_elim), 'h1FF);
      chk("t1_model_hidden", int'(model_hidden), 0);
      chk_result("t1", 20, 0, 0, 0);

      // Eight solved cells, last cell takes the missing digit.
      for (int i = 0; i < 8; i++) begin iv[i] = 9'h1 << i; ivl[i] = 9'h1 << i; end
      iv[8] = 9'h0; ivl[8] = 9'h1FF;
      run_sweep();
      chk("t2_model_elim", int'(model_elim), 'h100);
      chk_result("t2", 30, 0, 1, 8);
      chk("t2_cell8_value", int'(cval[8]), 'h100);

      // Duplicate digit.
      set_empty(); iv[1] = 9'h004; ivl[1] = 9'h004; iv[5] = 9'h004; ivl[5] = 9'h004;
      run_sweep();
      chk_result("t3", 20, 1, 0, 2);

      // Hidden single digit 5 in cell 3.
      for (int i = 0; i < 9; i++) begin iv[i] = 9'h0; ivl[i] = 9'h001; end
      ivl[3] = 9'h011;
      run_sweep();
      chk("t4_model_hidden", int'(model_hidden), 'h010);
      chk_result("t4", 30, 0, 1, 0);
      chk("t4_cell3_value", int'(cval[3]), 'h010);

      // Unsolved cell with no candidates.
      set_empty(); ivl[4] = 9'h0;
      run_sweep();
      chk_result("t5", 20, 1, 0, 0);

      // Reset mid-sweep, with an ignored start in cycle 5.
      set_empty(); load_cells();
      @(negedge clk); sw.start = 1'b1;
      @(posedge clk); #1; sw.start = 1'b0;
      repeat (4) @(posedge clk);
      #1; sw.start = 1'b1;
      @(posedge clk); #1; sw.start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("rst_c12_oe", int'(sw.cell_oe), 'h002);
      chk("rst_c12_addr", int'(sw.address), 2);
      reset = 1'b0;
      @(posedge clk); #1;
      chk_zero("rst_c13");
      reset = 1'b1;
      saw_done = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (sw.done || sw.busy) saw_done = 1'b1;
      end
      chk("rst_no_done", int'(saw_done), 0);
      for (int i = 0; i < 8; i++) begin iv[i] = 9'h1 << i; ivl[i] = 9'h1 << i; end
      iv[8] = 9'h0; ivl[8] = 9'h1FF;
      run_sweep();
      chk_result("rst_after", 30, 0, 1, 8);

      // Randomised groups.
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < 9; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
               iv[i]  = 9'h1 << $urandom_range(0, 8);
               ivl[i] = iv[i];
               if (r == 0 && $urandom_range(0, 3) == 0) iv[i] = 9'($urandom);
            end else begin
               iv[i] = 9'h0;
               if (r < 7) ivl[i] = (9'h1 << $urandom_range(0, 8)) | (9'h1 << $urandom_range(0, 8));
               else       ivl[i] = 9'($urandom);
            end
         end
         run_sweep();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
